// File: rtl/dmx_uart_loader_if.sv
// dmx_uart_loader_if: host-side UART line, packetizer slot port and status
// strobes of the DMX level loader, bundled for connection as one port.
interface dmx_uart_loader_if;
  logic       rx;
  logic [9:0] slot_index;
  logic [7:0] slot_byte;
  logic       cmd_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx, slot_index,
    input  slot_byte, cmd_done, frame_err, busy
  );

  modport slave (
    input  rx, slot_index,
    output slot_byte, cmd_done, frame_err, busy
  );
endinterface

// File: rtl/dmx_uart_loader.sv
// dmx_uart_loader: RS232 command receiver that fills a 512-slot DMX level
// buffer and serves slot_byte for the slot the packetizer is requesting.
// Command format: SYNC_BYTE, {7'b0, addr[8]}, addr[7:0], N (0 = 256), N data.
// Optional macro DMX_DOUBLE_BUFFER_EN: two banks, writes go to the back bank
// and the banks swap at the next frame start after a completed command.
module dmx_uart_loader #(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         TIMEOUT_CLKS = 120000,
  parameter logic [7:0] SYNC_BYTE    = 8'h7E
) (
  input logic               CLK12,
  input logic               RESET,
  dmx_uart_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      GAP_LAST = 17'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxst_t;
  typedef enum logic [2:0] {P_HUNT, P_ADDR_HI, P_ADDR_LO, P_COUNT, P_DATA} pst_t;

  // receiver state
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  rxst_t            rxst_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitn_q;
  logic [7:0]       shift_q;
  logic             byte_valid_q;
  logic             stop_bad;

  // parser state
  pst_t        pst_q;
  logic [8:0]  addr_q;
  logic [8:0]  rem_q;
  logic [16:0] gap_q;
  logic        busy_q, cmd_done_q, frame_err_q;
  logic        wr_en;

  logic [7:0]  slot_byte_q;
  logic        unused_idx_hi;

  assign unused_idx_hi = bus.slot_index[9];

  // A stop bit sampled low drops the byte and reports a framing error.
  assign stop_bad = (rxst_q == R_STOP) && (cnt_q == CNT_FULL) && !rx_s2_q;

  // UART receiver: synchroniser, start validation, 8 data bits LSB-first, stop
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rxst_q       <= R_IDLE;
      cnt_q        <= '0;
      bitn_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rx_s1_q      <= bus.rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      byte_valid_q <= 1'b0;
      case (rxst_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rxst_q <= R_START;
            cnt_q  <= '0;
          end
        end
        R_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q  <= '0;
            bitn_q <= '0;
            rxst_q <= rx_s2_q ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            if (bitn_q == 3'd7) rxst_q <= R_STOP;
            else                bitn_q <= bitn_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q        <= '0;
            rxst_q       <= R_IDLE;
            byte_valid_q <= rx_s2_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Command parser with inter-byte timeout; outputs registered with the state
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      pst_q       <= P_HUNT;
      busy_q      <= 1'b0;
      cmd_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      cmd_done_q  <= 1'b0;
      frame_err_q <= stop_bad;
      if (stop_bad) begin
        pst_q  <= P_HUNT;
        busy_q <= 1'b0;
        gap_q  <= '0;
      end else if (byte_valid_q) begin
        gap_q <= '0;
        case (pst_q)
          P_HUNT: begin
            if (shift_q == SYNC_BYTE) begin
              pst_q  <= P_ADDR_HI;
              busy_q <= 1'b1;
            end
          end
          P_ADDR_HI: begin
            if (shift_q[7:1] != 7'd0) begin
              frame_err_q <= 1'b1;
              pst_q       <= P_HUNT;
              busy_q      <= 1'b0;
            end else begin
              addr_q[8] <= shift_q[0];
              pst_q     <= P_ADDR_LO;
            end
          end
          P_ADDR_LO: begin
            addr_q[7:0] <= shift_q;
            pst_q       <= P_COUNT;
          end
          P_COUNT: begin
            rem_q <= (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
            pst_q <= P_DATA;
          end
          default: begin
            addr_q <= addr_q + 1'b1;
            if (rem_q == 9'd1) begin
              cmd_done_q <= 1'b1;
              pst_q      <= P_HUNT;
              busy_q     <= 1'b0;
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
        endcase
      end else if (pst_q != P_HUNT) begin
        if (gap_q == GAP_LAST) begin
          pst_q  <= P_HUNT;
          busy_q <= 1'b0;
          gap_q  <= '0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  // The write lands on the same edge that registers cmd_done.
  assign wr_en = byte_valid_q && (pst_q == P_DATA);

`ifdef DMX_DOUBLE_BUFFER_EN
  logic [7:0] mem_q [0:1023];
  logic       front_q, swap_pending_q;
  logic [9:0] idx_prev_q;
  logic       frame_start;

  assign frame_start = (bus.slot_index == 10'd1) && (idx_prev_q != 10'd1);

  // Bank select: swap at the first frame start after a completed command
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      front_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      idx_prev_q     <= '0;
    end else begin
      idx_prev_q <= bus.slot_index;
      if (frame_start && swap_pending_q) begin
        front_q        <= ~front_q;
        swap_pending_q <= cmd_done_q;
      end else if (cmd_done_q) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  // Back-bank write port
  always_ff @(posedge CLK12) begin
    if (wr_en) mem_q[{~front_q, addr_q}] <= shift_q;
  end

  // Front-bank registered read port
  always_ff @(posedge CLK12) begin
    if (RESET) slot_byte_q <= '0;
    else       slot_byte_q <= mem_q[{front_q, bus.slot_index[8:0]}];
  end
`else
  logic [7:0] mem_q [0:511];

  // Single-bank write port
  always_ff @(posedge CLK12) begin
    if (wr_en) mem_q[addr_q] <= shift_q;
  end

  // Registered read port; same-address write returns the old data
  always_ff @(posedge CLK12) begin
    if (RESET) slot_byte_q <= '0;
    else       slot_byte_q <= mem_q[bus.slot_index[8:0]];
  end
`endif

  assign bus.slot_byte = slot_byte_q;
  assign bus.cmd_done  = cmd_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmx_uart_loader.sv
// tb_dmx_uart_loader: directed bench for the DMX UART loader, with a short
// bit time and timeout so that a full 256-byte command fits the run.
module tb_dmx_uart_loader;
  localparam int CPB = 12;
  localparam int TO  = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_ferr   = 0;

  dmx_uart_loader_if bus ();

  dmx_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO),
    .SYNC_BYTE   (8'h7E)
  ) dut (
    .CLK12(clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_done)  n_done = n_done + 1;
      if (bus.frame_err) n_ferr = n_ferr + 1;
    end
  end

  typedef struct {
    logic [9:0] idx;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic read_slot(input logic [9:0] idx, output logic [7:0] v);
    bus.slot_index = idx;
    @(negedge clk);
    v = bus.slot_byte;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] pre;
    int         d0;
    int         f0;

    tbl[0] = '{10'd5,   8'hAA};
    tbl[1] = '{10'd6,   8'hBB};
    tbl[2] = '{10'd7,   8'hCC};
    tbl[3] = '{10'd511, 8'h11};
    tbl[4] = '{10'd0,   8'h22};
    tbl[5] = '{10'h020, 8'h55};
    tbl[6] = '{10'h021, 8'h77};
    tbl[7] = '{10'h040, 8'h00};
    tbl[8] = '{10'h041, 8'h01};
    tbl[9] = '{10'h13F, 8'hFF};

    bus.rx         = 1'b1;
    bus.slot_index = '0;
    repeat (4) @(negedge clk);
    check("reset slot_byte", 16'(bus.slot_byte), 16'h00);
    check("reset cmd_done",  16'(bus.cmd_done),  16'h0);
    check("reset frame_err", 16'(bus.frame_err), 16'h0);
    check("reset busy",      16'(bus.busy),      16'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // basic command: 3 bytes at slot 5
    send_byte(8'h7E, 1'b1);
    check("busy after sync", 16'(bus.busy), 16'h1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    check("cmd1 not done early", 16'(n_done), 16'd0);
    send_byte(8'hCC, 1'b1);
    check("cmd1 done count", 16'(n_done), 16'd1);
    check("cmd1 busy idle",  16'(bus.busy), 16'h0);
    check("cmd1 no ferr",    16'(n_ferr), 16'd0);

    // address wrap 511 -> 0
    send_byte(8'h7E, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("cmd2 done count", 16'(n_done), 16'd2);

    // bad stop bit in DATA, then recovery
    send_byte(8'h7E, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    check("stop-bit ferr",  16'(n_ferr), 16'd1);
    check("stop-bit hunt",  16'(bus.busy), 16'h0);
    check("stop-bit no done", 16'(n_done), 16'd2);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    check("recovery done", 16'(n_done), 16'd3);

    // bad address-high byte
    send_byte(8'h7E, 1'b1);
    send_byte(8'h02, 1'b1);
    check("hdr ferr", 16'(n_ferr), 16'd2);
    check("hdr hunt", 16'(bus.busy), 16'h0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h99, 1'b1);
    check("hdr tail ignored", 16'(n_done), 16'd3);
    check("hdr tail idle",    16'(bus.busy), 16'h0);

    // inter-byte timeout
    send_byte(8'h7E, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    check("timeout busy start", 16'(bus.busy), 16'h1);
    repeat (TO - 60) @(negedge clk);
    check("timeout not early", 16'(bus.busy), 16'h1);
    repeat (100) @(negedge clk);
    check("timeout busy clear", 16'(bus.busy), 16'h0);
    check("timeout no ferr",    16'(n_ferr), 16'd2);

    // COUNT = 0 means 256 bytes
    read_slot(10'h140, pre);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 255; i++) send_byte(8'(i), 1'b1);
    check("n256 not done at 255", 16'(n_done), 16'd3);
    check("n256 busy at 255",     16'(bus.busy), 16'h1);
    send_byte(8'hFF, 1'b1);
    check("n256 done", 16'(n_done), 16'd4);
    check("n256 idle", 16'(bus.busy), 16'h0);
    read_slot(10'h140, v);
    check("n256 no overrun", 16'(v), 16'(pre));

`ifdef DMX_DOUBLE_BUFFER_EN
    // bring the written bank to the front
    bus.slot_index = 10'd511;
    @(negedge clk);
    bus.slot_index = 10'd1;
    repeat (2) @(negedge clk);
`endif

    // slot readback table, one cycle after each index change
    for (int i = 0; i < 10; i++) begin
      read_slot(tbl[i].idx, v);
      check($sformatf("slot %0h", tbl[i].idx), 16'(v), 16'(tbl[i].exp));
    end

`ifdef DMX_DOUBLE_BUFFER_EN
    // write goes to the back bank and appears only after a frame start
    read_slot(10'd3, pre);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h40, 1'b1);
    read_slot(10'd3, v);
    check("dbuf held", 16'(v), 16'(pre));
    bus.slot_index = 10'd511;
    @(negedge clk);
    bus.slot_index = 10'd1;
    @(negedge clk);
    read_slot(10'd3, v);
    check("dbuf swapped", 16'(v), 16'h40);
`endif

    d0 = n_done;
    f0 = n_ferr;
    repeat (10) @(negedge clk);
    check("no stray done", 16'(n_done), 16'(d0));
    check("no stray ferr", 16'(n_ferr), 16'(f0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
